// File: rtl/key_onehot_capture_pkg.sv
// Shared constants and helpers for the key capture front end.
package key_onehot_capture_pkg;
  localparam int N_KEYS = 10;
  localparam logic [N_KEYS-1:0] KEY_NONE = '0;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Two's-complement trick isolates the lowest set bit.
  function automatic logic [N_KEYS-1:0] lowest_set(input logic [N_KEYS-1:0] v);
    return v & (~v + N_KEYS'(1));
  endfunction
endpackage

// File: rtl/key_onehot_capture_if.sv
// Key capture bus: raw keys and clear in, latched one-hot/strobe/held out.
interface key_onehot_capture_if;
  import key_onehot_capture_pkg::*;

  logic [N_KEYS-1:0] key_raw;
  logic              clr;
  logic [N_KEYS-1:0] key_onehot;
  logic              key_strobe;
  logic              key_held;

  modport master (output key_raw, clr, input key_onehot, key_strobe, key_held);
  modport slave  (input key_raw, clr, output key_onehot, key_strobe, key_held);
endinterface

// File: rtl/key_onehot_capture_debounce.sv
// One key: 2-FF synchroniser, tick-sampled history, debounced state.
module key_onehot_capture_debounce #(
  parameter int SAMPLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic tick,
  output logic deb
);
  logic               sync1;
  logic               sync2;
  logic [SAMPLES-2:0] hist;
  logic [SAMPLES-1:0] win;

  // Current sample plus the previous SAMPLES-1 ticks; deb moves only on full agreement.
  assign win = {hist, sync2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= '0;
      deb   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (tick) begin
        hist <= win[SAMPLES-2:0];
        if (&win) begin
          deb <= 1'b1;
        end else if (~|win) begin
          deb <= 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/key_onehot_capture.sv
// Ten-key capture: shared debounce tick, per-key debounce, lowest-index press latch.
module key_onehot_capture
  import key_onehot_capture_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int SAMPLES     = 4,
  parameter bit KEY_ACT_LOW = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  key_onehot_capture_if.slave  bus
);
  localparam int            CW        = clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0]     tick_cnt;
  logic              tick;
  logic [N_KEYS-1:0] raw_n;
  logic [N_KEYS-1:0] deb;
  logic [N_KEYS-1:0] deb_d;
  logic [N_KEYS-1:0] rise;

  assign raw_n = KEY_ACT_LOW ? ~bus.key_raw : bus.key_raw;
  assign tick  = (tick_cnt == TICK_LAST);
  assign rise  = deb & ~deb_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_onehot_capture_debounce #(.SAMPLES(SAMPLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_n[i]),
      .tick (tick),
      .deb  (deb[i])
    );
  end

  // A press always beats clr; simultaneous presses keep only the lowest index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_d          <= '0;
      bus.key_onehot <= KEY_NONE;
      bus.key_strobe <= 1'b0;
      bus.key_held   <= 1'b0;
    end else begin
      deb_d        <= deb;
      bus.key_held <= |deb;
      if (|rise) begin
        bus.key_onehot <= lowest_set(rise);
        bus.key_strobe <= 1'b1;
      end else begin
        bus.key_strobe <= 1'b0;
        if (bus.clr) begin
          bus.key_onehot <= KEY_NONE;
        end
      end
    end
  end
endmodule
